// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: optional dirty-victim write-back, block read, fill handshake.
// Build option: define REFILL_CRITICAL_WORD_FIRST_EN to start read beats at the missing word.
module cache_refill_ctrl #(
  parameter int ADD_SZ     = 16,
  parameter int W          = 32,
  parameter int B          = 2,
  parameter int BLK_OFF_SZ = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [ADD_SZ-1:0]   miss_addr,
  input  logic                victim_dirty,
  input  logic [ADD_SZ-1:0]   victim_addr,
  input  logic [B*W-1:0]      victim_data,
  output logic                fill_valid,
  input  logic                fill_ready,
  output logic [ADD_SZ-1:0]   fill_addr,
  output logic [B*W-1:0]      fill_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADD_SZ-1:0]   mem_addr,
  output logic [W-1:0]        mem_wdata,
  input  logic                mem_ack,
  input  logic [W-1:0]        mem_rdata,
  output logic [31:0]         refill_cnt
);

  localparam int TAG_SZ = ADD_SZ - BLK_OFF_SZ;

  typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_e;
  typedef logic [B-1:0][W-1:0] block_t;

  state_e                 state_q, state_d;
  logic [BLK_OFF_SZ-1:0]  beat_q, beat_d;
  logic [TAG_SZ-1:0]      miss_tag_q, miss_tag_d;
  logic [TAG_SZ-1:0]      vic_tag_q, vic_tag_d;
  block_t                 vic_data_q, vic_data_d;
  block_t                 fill_buf_q, fill_buf_d;
  logic [31:0]            refill_cnt_q, refill_cnt_d;

  logic                   accept;
  logic                   last_beat;
  logic [BLK_OFF_SZ-1:0]  rd_off;
  logic                   unused_bits;

  assign accept    = miss_valid && (state_q == IDLE);
  assign last_beat = (beat_q == BLK_OFF_SZ'(B - 1));

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  logic [BLK_OFF_SZ-1:0]  crit_off_q, crit_off_d;

  assign crit_off_d  = accept ? miss_addr[BLK_OFF_SZ-1:0] : crit_off_q;
  // The BLK_OFF_SZ-bit sum wraps modulo B, so the offset never carries into the tag.
  assign rd_off      = crit_off_q + beat_q;
  assign unused_bits = ^victim_addr[BLK_OFF_SZ-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crit_off_q <= '0;
    else        crit_off_q <= crit_off_d;
  end
`else
  assign rd_off      = beat_q;
  assign unused_bits = ^{victim_addr[BLK_OFF_SZ-1:0], miss_addr[BLK_OFF_SZ-1:0]};
`endif

  always_comb begin
    // NOTE: every next-state value and output gets a default first, so no path infers a latch.
    state_d      = state_q;
    beat_d       = beat_q;
    miss_tag_d   = miss_tag_q;
    vic_tag_d    = vic_tag_q;
    vic_data_d   = vic_data_q;
    fill_buf_d   = fill_buf_q;
    refill_cnt_d = refill_cnt_q;
    miss_ready   = 1'b0;
    fill_valid   = 1'b0;
    fill_addr    = '0;
    fill_data    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          miss_tag_d = miss_addr[ADD_SZ-1:BLK_OFF_SZ];
          vic_tag_d  = victim_addr[ADD_SZ-1:BLK_OFF_SZ];
          vic_data_d = victim_data;
          fill_buf_d = '0;
          beat_d     = '0;
          state_d    = victim_dirty ? WB : RD;
        end
      end

      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vic_tag_q, beat_q};
        mem_wdata = vic_data_q[beat_q];
        if (mem_ack) begin
          beat_d = last_beat ? '0 : beat_q + 1'b1;
          if (last_beat) state_d = RD;
        end
      end

      RD: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, rd_off};
        if (mem_ack) begin
          // Words land in their natural slot whatever order the beats were issued in.
          fill_buf_d[rd_off] = mem_rdata;
          beat_d             = last_beat ? '0 : beat_q + 1'b1;
          if (last_beat) state_d = FILL;
        end
      end

      FILL: begin
        fill_valid = 1'b1;
        fill_addr  = {miss_tag_q, {BLK_OFF_SZ{1'b0}}};
        fill_data  = fill_buf_q;
        if (fill_ready) begin
          state_d      = IDLE;
          refill_cnt_d = refill_cnt_q + 32'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      miss_tag_q   <= '0;
      vic_tag_q    <= '0;
      // NOTE: the block buffers are reset, unlike a RAM, because they are a few flops feeding outputs.
      vic_data_q   <= '0;
      fill_buf_q   <= '0;
      refill_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop takes the pre-edge _d value regardless of statement order.
      state_q      <= state_d;
      beat_q       <= beat_d;
      miss_tag_q   <= miss_tag_d;
      vic_tag_q    <= vic_tag_d;
      vic_data_q   <= vic_data_d;
      fill_buf_q   <= fill_buf_d;
      refill_cnt_q <= refill_cnt_d;
    end
  end

  assign refill_cnt = refill_cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus random misses against a block-level model.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

  localparam int ADD_SZ     = 16;
  localparam int W          = 32;
  localparam int B          = 2;
  localparam int BLK_OFF_SZ = 1;
  localparam int MAX_WAIT   = 200;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef struct {
    bit              we;
    logic [ADD_SZ-1:0] addr;
    logic [W-1:0]    data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              miss_valid;
  logic              miss_ready;
  logic [ADD_SZ-1:0] miss_addr;
  logic              victim_dirty;
  logic [ADD_SZ-1:0] victim_addr;
  logic [B*W-1:0]    victim_data;
  logic              fill_valid;
  logic              fill_ready;
  logic [ADD_SZ-1:0] fill_addr;
  logic [B*W-1:0]    fill_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADD_SZ-1:0] mem_addr;
  logic [W-1:0]      mem_wdata;
  logic              mem_ack = 1'b0;
  logic [W-1:0]      mem_rdata = '0;
  logic [31:0]       refill_cnt;

  cache_refill_ctrl #(
    .ADD_SZ(ADD_SZ), .W(W), .B(B), .BLK_OFF_SZ(BLK_OFF_SZ)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .refill_cnt(refill_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt;

  // Memory responder state (owned by the negedge process below).
  beat_t beat_log[$];
  int    stall_n  = 0;
  bit    junk_ack = 1'b0;
  int    stab_err = 0;
  int    wait_cnt = 0;
  bit    hold_v   = 1'b0;
  beat_t hold_b;
  bit    prev_req = 1'b0;
  bit    prev_ack = 1'b0;
  beat_t prev_b;

  function automatic logic [W-1:0] rd_word(input logic [ADD_SZ-1:0] a);
    logic [ADD_SZ-1:0] s;
    s = a + 16'hA000;
    return W'(s);
  endfunction

  // Memory model: acks each beat after stall_n idle cycles, logs completed beats,
  // and flags any request field that moves while a beat is outstanding.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
      hold_v   = 1'b0;
      wait_cnt = 0;
      mem_ack  = 1'b0;
    end else begin
      if (prev_req && prev_ack) begin
        beat_log.push_back(prev_b);
        hold_v   = 1'b0;
        wait_cnt = 0;
      end
      if (hold_v && (mem_req !== 1'b1 || mem_addr !== hold_b.addr ||
                     mem_we !== hold_b.we || mem_wdata !== hold_b.data))
        stab_err++;
      if (mem_req === 1'b1) begin
        if (!hold_v) begin
          hold_v      = 1'b1;
          hold_b.we   = mem_we;
          hold_b.addr = mem_addr;
          hold_b.data = mem_wdata;
        end
        if (wait_cnt >= stall_n) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_word(mem_addr);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        hold_v    = 1'b0;
        wait_cnt  = 0;
        mem_ack   = junk_ack;
        mem_rdata = $urandom;
      end
      prev_req    = (mem_req === 1'b1);
      prev_ack    = mem_ack;
      prev_b.we   = mem_we;
      prev_b.addr = mem_addr;
      prev_b.data = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // One complete miss: model the expected beats, fill and latency from the request alone.
  task automatic do_miss(input logic [ADD_SZ-1:0] maddr, input bit dirty,
                         input logic [ADD_SZ-1:0] vaddr, input logic [B*W-1:0] vdata,
                         input int stall, input int bp, input string tag);
    beat_t             exp_q[$];
    beat_t             b;
    logic [ADD_SZ-1:0] base, vbase;
    logic [B*W-1:0]    exp_fill;
    int                moff, off, cyc, exp_lat;

    base  = ADD_SZ'((int'(maddr) / B) * B);
    vbase = ADD_SZ'((int'(vaddr) / B) * B);
    moff  = int'(maddr) % B;
    if (dirty) begin
      for (int k = 0; k < B; k++) begin
        b.we = 1'b1; b.addr = ADD_SZ'(vbase + k); b.data = vdata[k*W +: W];
        exp_q.push_back(b);
      end
    end
    for (int k = 0; k < B; k++) begin
      off  = CWF ? (moff + k) % B : k;
      b.we = 1'b0; b.addr = ADD_SZ'(base + off); b.data = '0;
      exp_q.push_back(b);
      exp_fill[k*W +: W] = rd_word(ADD_SZ'(base + k));
    end
    exp_lat = (dirty ? 2 : 1) * B * (stall + 1);

    beat_log.delete();
    stall_n = stall;
    check({tag, ".ready"}, miss_ready, 1'b1);
    miss_valid = 1'b1; miss_addr = maddr; victim_dirty = dirty;
    victim_addr = vaddr; victim_data = vdata;
    tick();
    // Scramble the request inputs; the transaction in flight must not notice.
    miss_valid = 1'b0; miss_addr = $urandom; victim_dirty = $urandom;
    victim_addr = $urandom; victim_data = {$urandom, $urandom};
    check({tag, ".busy"}, miss_ready, 1'b0);

    cyc = 0;
    while (fill_valid !== 1'b1 && cyc < MAX_WAIT) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, cyc, exp_lat);
    check({tag, ".fill_valid"}, fill_valid, 1'b1);
    check({tag, ".fill_addr"}, fill_addr, base);
    check({tag, ".fill_data"}, fill_data, exp_fill);
    check({tag, ".cnt_hold"}, refill_cnt, exp_cnt);

    for (int i = 0; i < bp; i++) begin
      tick();
      check($sformatf("%s.bp%0d.valid", tag, i), fill_valid, 1'b1);
      check($sformatf("%s.bp%0d.data", tag, i), fill_data, exp_fill);
      check($sformatf("%s.bp%0d.addr", tag, i), fill_addr, base);
      check($sformatf("%s.bp%0d.miss_ready", tag, i), miss_ready, 1'b0);
      check($sformatf("%s.bp%0d.cnt", tag, i), refill_cnt, exp_cnt);
    end

    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    exp_cnt++;
    check({tag, ".cnt_inc"}, refill_cnt, exp_cnt);
    check({tag, ".fill_done"}, fill_valid, 1'b0);
    check({tag, ".idle"}, miss_ready, 1'b1);
    check({tag, ".mem_idle"}, mem_req, 1'b0);

    check({tag, ".nbeats"}, beat_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < beat_log.size()) begin
        check($sformatf("%s.beat%0d.we", tag, i), beat_log[i].we, exp_q[i].we);
        check($sformatf("%s.beat%0d.addr", tag, i), beat_log[i].addr, exp_q[i].addr);
        if (exp_q[i].we)
          check($sformatf("%s.beat%0d.wdata", tag, i), beat_log[i].data, exp_q[i].data);
      end
    end
    check({tag, ".stable"}, stab_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; miss_valid = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
    victim_addr = '0; victim_data = '0; fill_ready = 1'b0;
    exp_cnt = '0;
    #2;
    check("rst.miss_ready", miss_ready, 1'b1);
    check("rst.fill_valid", fill_valid, 1'b0);
    check("rst.mem_req", mem_req, 1'b0);
    check("rst.mem_we", mem_we, 1'b0);
    check("rst.mem_addr", mem_addr, '0);
    check("rst.mem_wdata", mem_wdata, '0);
    check("rst.fill_addr", fill_addr, '0);
    check("rst.fill_data", fill_data, '0);
    check("rst.refill_cnt", refill_cnt, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Clean miss, memory always ready, junk acks while idle.
    junk_ack = 1'b1;
    do_miss(16'h1235, 1'b0, 16'h0000, '0, 0, 0, "clean");
    // Dirty miss: write-back of the victim then the block read.
    junk_ack = 1'b0;
    do_miss(16'h0082, 1'b1, 16'h0040, {32'hDEADBEEF, 32'hCAFEF00D}, 0, 0, "dirty");
    // Memory stall of five cycles per beat.
    do_miss(16'h1235, 1'b0, 16'h0000, '0, 5, 0, "stall");
    do_miss(16'h2001, 1'b1, 16'h3003, {32'h11112222, 32'h33334444}, 5, 0, "stall_dirty");
    // Fill backpressure.
    do_miss(16'h4567, 1'b0, 16'h0000, '0, 0, 4, "bp");
    // Top of the address space: offsets must wrap without carrying.
    do_miss(16'hFFFF, 1'b1, 16'hFFFF, {32'h0BADF00D, 32'h12345678}, 1, 1, "top");

    // Reset in the middle of a write-back, after beat 0 has been acked.
    beat_log.delete();
    stall_n = 0;
    miss_valid = 1'b1; miss_addr = 16'h0082; victim_dirty = 1'b1;
    victim_addr = 16'h0040; victim_data = {32'hDEADBEEF, 32'hCAFEF00D};
    tick();
    miss_valid = 1'b0;
    tick();
    check("rstwb.pre_we", mem_we, 1'b1);
    check("rstwb.pre_addr", mem_addr, 16'h0041);
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    check("rstwb.mem_req", mem_req, 1'b0);
    check("rstwb.miss_ready", miss_ready, 1'b1);
    check("rstwb.fill_valid", fill_valid, 1'b0);
    check("rstwb.refill_cnt", refill_cnt, exp_cnt);
    check("rstwb.mem_addr", mem_addr, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rstwb.nbeats", beat_log.size(), 1);
    if (beat_log.size() > 0)
      check("rstwb.beat0.addr", beat_log[0].addr, 16'h0040);
    check("rstwb.no_fill", fill_valid, 1'b0);
    do_miss(16'h1235, 1'b0, 16'h0000, '0, 0, 0, "after_rst");

    // Random misses.
    for (int n = 0; n < 10; n++) begin
      junk_ack = 1'($urandom_range(0, 1));
      do_miss(ADD_SZ'($urandom), 1'($urandom_range(0, 1)), ADD_SZ'($urandom),
              {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
              $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
